// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the CPU ibus/dbus memory arbiter.
// Kept separate so the arbiter top and its priority sub-block agree on encodings.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUSY = 3'd1,
    D_BUSY = 3'd2,
    I_DONE = 3'd3,
    D_DONE = 3'd4
  } arb_state_t;

  typedef enum logic {
    M_IBUS = 1'b0,
    M_DBUS = 1'b1
  } master_id_t;

  localparam int TMO_W = 16;
  localparam int STARVE_W = 4;

  function automatic logic is_busy(arb_state_t s);
    return (s == I_BUSY) || (s == D_BUSY);
  endfunction

endpackage

// File: rtl/arb_priority.sv
// Winner select for the shared memory port: dbus has priority, but ibus is
// forced through once dbus has been granted STARVE_LIMIT times in a row over it.
module arb_priority
  import bus_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic       req_d,
  input  logic       grant_pulse,
  output master_id_t winner
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;

  assign starved = req_i && (starve_cnt == LIMIT);

  always_comb begin
    winner = M_DBUS;
    if (starved)     winner = M_IBUS;
    else if (req_d)  winner = M_DBUS;
    else if (req_i)  winner = M_IBUS;
  end

  // Only counts dbus wins that actually made ibus wait; any gap in ibus demand resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!req_i || (grant_pulse && winner == M_IBUS)) begin
      starve_cnt <= '0;
    end else if (grant_pulse && winner == M_DBUS && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares one waitrequest-style memory slave between the CPU ibus and dbus,
// stalling the losing master and returning read data through per-master registers.
//
//   state  | meaning
//   IDLE   | no transfer in flight; arbitrate and launch the winner
//   I_BUSY | ibus transfer on the slave port, waiting for waitrequest low
//   D_BUSY | dbus transfer on the slave port, waiting for waitrequest low
//   I_DONE | ibus result ready, ibus_stall low for this cycle
//   D_DONE | dbus result ready, dbus_stall low for this cycle
module cpu_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [31:0] ibus_address,
  input  logic [3:0]  ibus_byteenable,
  input  logic [31:0] ibus_wrdata,
  input  logic        ibus_read,
  input  logic        ibus_write,
  output logic [31:0] ibus_rddata,
  output logic        ibus_stall,

  input  logic [31:0] dbus_address,
  input  logic [3:0]  dbus_byteenable,
  input  logic [31:0] dbus_wrdata,
  input  logic        dbus_read,
  input  logic        dbus_write,
  output logic [31:0] dbus_rddata,
  output logic        dbus_stall,

  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_wrdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rddata,
  input  logic        mem_waitrequest,

  output logic        bus_error
);

  arb_state_t         state, state_nxt;
  master_id_t         winner;
  logic               req_i, req_d;
  logic               grant, xfer_ok, tmo_hit, tmo_expire, sel_d;
  logic [TMO_W-1:0]   tmo_cnt;

  assign req_i = ibus_read | ibus_write;
  assign req_d = dbus_read | dbus_write;
  assign sel_d = (winner == M_DBUS);

  assign ibus_stall = req_i & (state != I_DONE);
  assign dbus_stall = req_d & (state != D_DONE);

  assign tmo_expire = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_W'(1));

  arb_priority #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_priority (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .req_d       (req_d),
    .grant_pulse (grant),
    .winner      (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    xfer_ok   = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_i || req_d) begin
          grant     = 1'b1;
          state_nxt = sel_d ? D_BUSY : I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        // The transfer finishes even if the requester has dropped its strobe.
        if (!mem_waitrequest) begin
          xfer_ok   = 1'b1;
          state_nxt = (state == I_BUSY) ? I_DONE : D_DONE;
        end else if (tmo_expire) begin
          tmo_hit   = 1'b1;
          state_nxt = (state == I_BUSY) ? I_DONE : D_DONE;
        end
      end
      I_DONE, D_DONE: state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // A write wins when the CPU raises both strobes, so read is masked by write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_wrdata     <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
    end else if (grant) begin
      mem_address    <= sel_d ? dbus_address    : ibus_address;
      mem_byteenable <= sel_d ? dbus_byteenable : ibus_byteenable;
      mem_wrdata     <= sel_d ? dbus_wrdata     : ibus_wrdata;
      mem_write      <= sel_d ? dbus_write      : ibus_write;
      mem_read       <= sel_d ? (dbus_read & ~dbus_write) : (ibus_read & ~ibus_write);
    end else if (xfer_ok || tmo_hit) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibus_rddata <= '0;
      dbus_rddata <= '0;
    end else if (xfer_ok && mem_read) begin
      if (state == I_BUSY) ibus_rddata <= mem_rddata;
      else                 dbus_rddata <= mem_rddata;
    end else if (tmo_hit) begin
      if (state == I_BUSY) ibus_rddata <= '0;
      else                 dbus_rddata <= '0;
    end
  end

  // Down-counter loaded at grant; expiry is the terminal count of 1 while still waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (grant) begin
      tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
    end else if (is_busy(state) && mem_waitrequest && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_error <= 1'b0;
    else        bus_error <= tmo_hit;
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter with STARVE_LIMIT=4 and TIMEOUT_CYCLES=8.
module tb_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ibus_address = '0, ibus_wrdata = '0, dbus_address = '0, dbus_wrdata = '0;
  logic [3:0]  ibus_byteenable = 4'hF, dbus_byteenable = 4'hF;
  logic        ibus_read = 1'b0, ibus_write = 1'b0, dbus_read = 1'b0, dbus_write = 1'b0;
  logic [31:0] ibus_rddata, dbus_rddata;
  logic        ibus_stall, dbus_stall;
  logic [31:0] mem_address, mem_wrdata;
  logic [3:0]  mem_byteenable;
  logic        mem_read, mem_write;
  logic [31:0] mem_rddata = '0;
  logic        mem_waitrequest = 1'b1;
  logic        bus_error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  cpu_bus_arbiter #(
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ibus_address    (ibus_address),
    .ibus_byteenable (ibus_byteenable),
    .ibus_wrdata     (ibus_wrdata),
    .ibus_read       (ibus_read),
    .ibus_write      (ibus_write),
    .ibus_rddata     (ibus_rddata),
    .ibus_stall      (ibus_stall),
    .dbus_address    (dbus_address),
    .dbus_byteenable (dbus_byteenable),
    .dbus_wrdata     (dbus_wrdata),
    .dbus_read       (dbus_read),
    .dbus_write      (dbus_write),
    .dbus_rddata     (dbus_rddata),
    .dbus_stall      (dbus_stall),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_wrdata      (mem_wrdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_rddata      (mem_rddata),
    .mem_waitrequest (mem_waitrequest),
    .bus_error       (bus_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int c_d, c_i, d_grants;
    logic seen_i, prev_rd;

    // Reset
    #2 rst_n = 1'b0;
    tick();
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_ibus_rddata", ibus_rddata, 32'd0);
    chk("rst_dbus_rddata", dbus_rddata, 32'd0);
    chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
    ibus_read = 1'b1;
    #1;
    chk("rst_stall_follows_req", {31'd0, ibus_stall}, 32'd1);
    ibus_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // 1: lone ibus read, 4 wait cycles
    ibus_address = 32'h8000_0000;
    ibus_read = 1'b1;
    mem_waitrequest = 1'b1;
    #1;
    chk("t1_stall_idle", {31'd0, ibus_stall}, 32'd1);
    tick();
    chk("t1_mem_address", mem_address, 32'h8000_0000);
    for (int k = 0; k < 5; k++) begin
      chk("t1_mem_read_busy", {31'd0, mem_read}, 32'd1);
      if (k == 4) begin
        mem_waitrequest = 1'b0;
        mem_rddata = 32'h3C08_DEAD;
      end
      tick();
    end
    chk("t1_mem_read_done", {31'd0, mem_read}, 32'd0);
    chk("t1_stall_done", {31'd0, ibus_stall}, 32'd0);
    chk("t1_ibus_rddata", ibus_rddata, 32'h3C08_DEAD);
    chk("t1_no_bus_error", {31'd0, bus_error}, 32'd0);
    tick();
    chk("t1_stall_back_high", {31'd0, ibus_stall}, 32'd1);
    ibus_read = 1'b0;
    tick();
    chk("t1_no_regrant", {31'd0, mem_read}, 32'd0);

    // 2: simultaneous ibus/dbus reads, zero-wait slave
    ibus_address = 32'h8000_0040;
    dbus_address = 32'h0000_0200;
    ibus_read = 1'b1;
    dbus_read = 1'b1;
    mem_waitrequest = 1'b0;
    c_d = -1;
    c_i = -1;
    tick();
    chk("t2_first_grant_dbus", mem_address, 32'h0000_0200);
    mem_rddata = 32'hD00D_F00D;
    tick();
    chk("t2_dbus_stall_low", {31'd0, dbus_stall}, 32'd0);
    chk("t2_ibus_still_stalled", {31'd0, ibus_stall}, 32'd1);
    chk("t2_dbus_rddata", dbus_rddata, 32'hD00D_F00D);
    c_d = cyc;
    dbus_read = 1'b0;
    tick();
    tick();
    chk("t2_second_grant_ibus", mem_address, 32'h8000_0040);
    mem_rddata = 32'h27BD_FFF8;
    tick();
    chk("t2_ibus_stall_low", {31'd0, ibus_stall}, 32'd0);
    chk("t2_ibus_rddata", ibus_rddata, 32'h27BD_FFF8);
    c_i = cyc;
    chk("t2_stall_gap", 32'(c_i - c_d), 32'd3);
    ibus_read = 1'b0;
    tick();

    // 3: dbus write with both strobes raised
    dbus_address = 32'h0000_0010;
    dbus_byteenable = 4'b0011;
    dbus_wrdata = 32'h1234_ABCD;
    dbus_write = 1'b1;
    dbus_read = 1'b1;
    mem_waitrequest = 1'b1;
    mem_rddata = 32'hFFFF_FFFF;
    tick();
    chk("t3_mem_write", {31'd0, mem_write}, 32'd1);
    chk("t3_mem_read", {31'd0, mem_read}, 32'd0);
    chk("t3_mem_byteenable", {28'd0, mem_byteenable}, 32'h3);
    chk("t3_mem_wrdata", mem_wrdata, 32'h1234_ABCD);
    chk("t3_mem_address", mem_address, 32'h0000_0010);
    mem_waitrequest = 1'b0;
    tick();
    chk("t3_mem_write_cleared", {31'd0, mem_write}, 32'd0);
    chk("t3_dbus_stall_low", {31'd0, dbus_stall}, 32'd0);
    chk("t3_dbus_rddata_kept", dbus_rddata, 32'hD00D_F00D);
    dbus_write = 1'b0;
    dbus_read = 1'b0;
    dbus_byteenable = 4'hF;
    tick();

    // 4: starvation guard
    ibus_address = 32'h8000_0004;
    dbus_address = 32'h0000_0100;
    ibus_read = 1'b1;
    dbus_read = 1'b1;
    mem_waitrequest = 1'b0;
    mem_rddata = 32'h1111_2222;
    d_grants = 0;
    seen_i = 1'b0;
    prev_rd = 1'b0;
    for (int c = 0; c < 40 && !seen_i; c++) begin
      tick();
      if (mem_read && !prev_rd) begin
        if (mem_address == 32'h8000_0004) seen_i = 1'b1;
        else d_grants++;
      end
      prev_rd = mem_read;
    end
    chk("t4_ibus_granted", {31'd0, seen_i}, 32'd1);
    chk("t4_dbus_grants_before", 32'(d_grants), 32'd4);
    tick();
    chk("t4_ibus_stall_low", {31'd0, ibus_stall}, 32'd0);
    chk("t4_ibus_rddata", ibus_rddata, 32'h1111_2222);
    ibus_read = 1'b0;
    dbus_read = 1'b0;
    tick();

    // 5: timeout with waitrequest stuck high
    dbus_address = 32'h0000_0300;
    dbus_read = 1'b1;
    mem_waitrequest = 1'b1;
    mem_rddata = 32'h5555_AAAA;
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk("t5_busy_mem_read", {31'd0, mem_read}, 32'd1);
      chk("t5_busy_no_error", {31'd0, bus_error}, 32'd0);
      tick();
    end
    chk("t5_bus_error_pulse", {31'd0, bus_error}, 32'd1);
    chk("t5_dbus_stall_low", {31'd0, dbus_stall}, 32'd0);
    chk("t5_dbus_rddata_zero", dbus_rddata, 32'd0);
    chk("t5_mem_read_dropped", {31'd0, mem_read}, 32'd0);
    dbus_read = 1'b0;
    tick();
    chk("t5_bus_error_cleared", {31'd0, bus_error}, 32'd0);
    tick();
    chk("t5_idle_no_grant", {31'd0, mem_read}, 32'd0);

    // 6: async reset in D_BUSY
    dbus_address = 32'h0000_0400;
    dbus_read = 1'b1;
    mem_waitrequest = 1'b1;
    tick();
    chk("t6_busy_mem_read", {31'd0, mem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_mem_read_async_drop", {31'd0, mem_read}, 32'd0);
    chk("t6_stall_in_reset", {31'd0, dbus_stall}, 32'd1);
    dbus_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_mem_address_reset", mem_address, 32'd0);
    chk("t6_ibus_rddata_reset", ibus_rddata, 32'd0);
    chk("t6_dbus_stall_reset", {31'd0, dbus_stall}, 32'd0);
    chk("t6_bus_error_reset", {31'd0, bus_error}, 32'd0);
    dbus_address = 32'h0000_0020;
    dbus_read = 1'b1;
    tick();
    chk("t6_idle_after_reset", {31'd0, mem_read}, 32'd1);
    chk("t6_regrant_address", mem_address, 32'h0000_0020);
    mem_waitrequest = 1'b0;
    mem_rddata = 32'hCAFE_F00D;
    tick();
    chk("t6_dbus_rddata", dbus_rddata, 32'hCAFE_F00D);
    dbus_read = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
